// File: rtl/rot_pkg.sv
// Shared constants and types for the pipelined rotate units.
// Used by rotl_pipe and its rotl_stage sub-module.
package rot_pkg;

    localparam int ROT_WIDTH = 32;
    localparam int ROT_AMT_W = 5;

    typedef logic [ROT_WIDTH-1:0] rot_data_t;
    typedef logic [ROT_AMT_W-1:0] rot_amt_t;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_e;

endpackage

// File: rtl/rotl_stage.sv
// One log-stage of the rotate pipeline: rotates by SHIFT when its
// amount bit is set and holds valid/data/amount with a skid-free ready.
import rot_pkg::*;

module rotl_stage #(
    parameter int WIDTH = ROT_WIDTH,
    parameter int AMT_W = ROT_AMT_W,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AMT_W-1:0] i_amt,
    input  logic             i_nxt_ready,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [AMT_W-1:0] o_amt
);

    localparam int BIT = $clog2(SHIFT);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_amt;
    logic [WIDTH-1:0] w_rot;

    assign w_rot = i_amt[BIT]
        ? {i_data[WIDTH-1-SHIFT:0], i_data[WIDTH-1:WIDTH-SHIFT]}
        : i_data;

    // An empty stage always accepts, so bubbles collapse.
    assign o_ready = !r_valid || i_nxt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_rot;
                r_amt  <= i_amt;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;

endmodule

// File: rtl/rotl_pipe.sv
// Pipelined WIDTH-bit rotate-left, one stage per amount bit, valid/ready.
// Define ROTL_PIPE_DIR_EN to add rot_dir (1 = rotate right).
import rot_pkg::*;

module rotl_pipe #(
    parameter int WIDTH = ROT_WIDTH,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_data,
    input  logic [AMT_W-1:0] rot_amount,
`ifdef ROTL_PIPE_DIR_EN
    input  logic             rot_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_data
);

    logic [AMT_W:0]   w_valid;
    logic [AMT_W:0]   w_ready;
    logic [WIDTH-1:0] w_data [0:AMT_W];
    logic [AMT_W-1:0] w_amt  [0:AMT_W];
    logic             w_unused_amt;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("rotl_pipe: WIDTH must be a power of two >= 2");
    end

`ifdef ROTL_PIPE_DIR_EN
    // Right rotate by n equals left rotate by (WIDTH - n) mod WIDTH.
    always_comb begin
        w_amt[0] = rot_amount;
        if (rot_dir_e'(rot_dir) == ROT_RIGHT) begin
            w_amt[0] = -rot_amount;
        end
    end
`else
    assign w_amt[0] = rot_amount;
`endif

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = input_data;
    assign w_ready[AMT_W] = out_ready;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        rotl_stage #(
            .WIDTH (WIDTH),
            .AMT_W (AMT_W),
            .SHIFT (1 << k)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_valid     (w_valid[k]),
            .i_data      (w_data[k]),
            .i_amt       (w_amt[k]),
            .i_nxt_ready (w_ready[k+1]),
            .o_ready     (w_ready[k]),
            .o_valid     (w_valid[k+1]),
            .o_data      (w_data[k+1]),
            .o_amt       (w_amt[k+1])
        );
    end

    assign in_ready     = w_ready[0];
    assign out_valid    = w_valid[AMT_W];
    assign output_data  = w_data[AMT_W];
    assign w_unused_amt = ^w_amt[AMT_W];

endmodule
